// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding, default line settings,
// and small helpers for the baud divider and mid-bit majority vote.
package uart_defs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned DEF_CLK_HZ = 32'd50_000_000;
    localparam int unsigned DEF_BAUD   = 32'd115_200;
    localparam int unsigned DEF_OVS    = 32'd16;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned ovs);
        return clk_hz / (baud * ovs);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: clk divider pulses tick every DIV clocks and ovs_cnt
// counts ticks within one bit. Both counters sit at zero while restart is high.
module uart_baud_tick #(
    parameter  int unsigned DIV = 32'd27,
    parameter  int unsigned OVS = 32'd16,
    localparam int unsigned DCW = (DIV > 32'd1) ? $clog2(DIV) : 32'd1,
    localparam int unsigned OCW = $clog2(OVS)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           restart,
    output logic           tick,
    output logic [OCW-1:0] ovs_cnt
);

    logic [DCW-1:0] div_q, div_d;
    logic [OCW-1:0] ovs_q, ovs_d;
    logic           wrap_s;

    // Next-state for the divider and the tick-within-bit counter
    always_comb begin
        wrap_s = (div_q == DCW'(DIV - 32'd1));
        div_d  = div_q;
        ovs_d  = ovs_q;
        if (restart) begin
            div_d = {DCW{1'b0}};
            ovs_d = {OCW{1'b0}};
        end else if (wrap_s) begin
            div_d = {DCW{1'b0}};
            ovs_d = (ovs_q == OCW'(OVS - 32'd1)) ? {OCW{1'b0}} : ovs_q + OCW'(1);
        end else begin
            div_d = div_q + DCW'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= {DCW{1'b0}};
            ovs_q <= {OCW{1'b0}};
        end else begin
            div_q <= div_d;
            ovs_q <= ovs_d;
        end
    end

    assign tick    = wrap_s & ~restart;
    assign ovs_cnt = ovs_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronized input, oversampled mid-bit sampling, one-byte holding
// register with valid/ack handshake, framing-error pulse and sticky overrun flag.
module uart_rx_core
    import uart_defs_pkg::*;
#(
    parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
    parameter int unsigned BAUD      = DEF_BAUD,
    parameter int unsigned DATA_BITS = 32'd8,
    parameter int unsigned OVS       = DEF_OVS
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int unsigned    DIV    = calc_div(CLK_HZ, BAUD, OVS);
    localparam int unsigned    OCW    = $clog2(OVS);
    localparam logic [OCW-1:0] T6     = OCW'(6);
    localparam logic [OCW-1:0] T7     = OCW'(7);
    localparam logic [OCW-1:0] T8     = OCW'(8);
    localparam logic [OCW-1:0] T_LAST = OCW'(OVS - 32'd1);
    localparam logic [3:0]     B_LAST = 4'(DATA_BITS - 32'd1);

    uart_state_e          state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic                 prev_q, prev_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           maj_q, maj_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;
    logic                 rx_s, fall_s, tick_s, deliver_s, ack_s;
    logic [OCW-1:0]       ovs_s;

    uart_baud_tick #(
        .DIV (DIV),
        .OVS (OVS)
    ) u_tick (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .restart (state_q == ST_IDLE),
        .tick    (tick_s),
        .ovs_cnt (ovs_s)
    );

    // Receive FSM, sampling and holding-register next-state
    always_comb begin
        rx_s      = sync_q[1];
        fall_s    = prev_q & ~rx_s;
        sync_d    = {sync_q[0], uart_rx};
        prev_d    = rx_s;
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        maj_d     = maj_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        ferr_d    = 1'b0;
        deliver_s = 1'b0;

        if (tick_s && (ovs_s == T6)) begin
            maj_d[0] = rx_s;
        end else if (tick_s && (ovs_s == T7)) begin
            maj_d[1] = rx_s;
        end else begin
            maj_d = maj_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_s) state_d = ST_START;
                else        state_d = ST_IDLE;
            end
            // Start is validated mid-bit but DATA is entered only at the bit boundary
            ST_START: begin
                if (tick_s && (ovs_s == T7) && rx_s) begin
                    state_d = ST_IDLE;
                end else if (tick_s && (ovs_s == T_LAST)) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 4'd0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s && (ovs_s == T8)) begin
                    shift_d   = {maj3(maj_q[0], maj_q[1], rx_s), shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    state_d   = (bit_cnt_q == B_LAST) ? ST_STOP : ST_DATA;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick_s && (ovs_s == T7)) begin
                    state_d   = ST_IDLE;
                    deliver_s = rx_s;
                    ferr_d    = ~rx_s;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        ack_s  = rx_ack & valid_q;

        // An ack in the same cycle frees the holding register for the new byte
        if (deliver_s && (!valid_q || ack_s)) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = 1'b0;
        end else if (deliver_s) begin
            ovr_d = 1'b1;
        end else if (ack_s) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and output registers; synchronizer presets to idle-high
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            sync_q    <= 2'b11;
            prev_q    <= 1'b1;
            bit_cnt_q <= 4'd0;
            shift_q   <= {DATA_BITS{1'b0}};
            maj_q     <= 2'b00;
            data_q    <= {DATA_BITS{1'b0}};
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            maj_q     <= maj_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;
    assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: serial frames driven at 432 clk/bit, received bytes
// and flag activity collected by a monitor and compared with a queue-based reference.
module tb_uart_rx_core;

    localparam int BIT = 432;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack = 1'b1;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int total = 0;
    int bad = 0;

    int   cyc = 0;
    logic pv = 1'b0, pe = 1'b0, pb = 1'b0;
    int   vrun = 0, erun = 0, brun = 0;
    int   last_vlen = 0, last_elen = 0, last_blen = 0;
    int   err_cnt = 0, vrise_cyc = 0;
    logic [7:0] got_q[$];

    uart_rx_core dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .uart_rx      (uart_rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ack       (rx_ack),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    always #10 sys_clk = ~sys_clk;

    // Monitor: records received bytes and the length of every valid/error/busy pulse
    always @(negedge sys_clk) begin
        cyc <= cyc + 1;
        pv  <= rx_valid;
        pe  <= rx_frame_err;
        pb  <= rx_busy;
        if (rx_valid && !pv) begin
            got_q.push_back(rx_data);
            vrise_cyc <= cyc;
        end
        if (rx_frame_err && !pe) err_cnt <= err_cnt + 1;
        vrun <= rx_valid ? vrun + 1 : 0;
        erun <= rx_frame_err ? erun + 1 : 0;
        brun <= rx_busy ? brun + 1 : 0;
        if (!rx_valid && pv) last_vlen <= vrun;
        if (!rx_frame_err && pe) last_elen <= erun;
        if (!rx_busy && pb) last_blen <= brun;
    end

    task automatic idle_bits(input int n);
        repeat (n * BIT) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge sys_clk);
        end
        uart_rx = stop_bit;
        repeat (BIT) @(negedge sys_clk);
        uart_rx = 1'b1;
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        repeat (5) @(negedge sys_clk);
        total++;
        if ({rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=000",
                     {rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy});
        end
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic test_single_a5;
        int n0, e0, start_c, lat;
        n0 = got_q.size();
        e0 = err_cnt;
        rx_ack = 1'b1;
        start_c = cyc;
        send_frame(8'hA5, 1'b1);
        idle_bits(1);
        lat = vrise_cyc - start_c;
        total++;
        if (got_q.size() !== n0 + 1) begin
            bad++;
            $display("FAIL a5_count got=%0d want=%0d", got_q.size() - n0, 1);
        end else begin
            total++;
            if (got_q[n0] !== 8'hA5) begin
                bad++;
                $display("FAIL a5_data got=%h want=a5", got_q[n0]);
            end
        end
        total++;
        if (last_vlen !== 1) begin
            bad++;
            $display("FAIL a5_valid_len got=%0d want=1", last_vlen);
        end
        total++;
        if (err_cnt !== e0 || rx_overrun !== 1'b0) begin
            bad++;
            $display("FAIL a5_flags got=err%0d/ovr%b want=0/0", err_cnt - e0, rx_overrun);
        end
        total++;
        if (lat < 4100 || lat > 4115) begin
            bad++;
            $display("FAIL a5_latency got=%0d want=4100..4115", lat);
        end
        total++;
        if (last_blen < 4090 || last_blen > 4115) begin
            bad++;
            $display("FAIL a5_busy_len got=%0d want=4090..4115", last_blen);
        end
    endtask

    task automatic test_back_to_back;
        int n0;
        n0 = got_q.size();
        rx_ack = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_bits(1);
        total++;
        if (got_q.size() !== n0 + 2) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=2", got_q.size() - n0);
        end else begin
            total++;
            if (got_q[n0] !== 8'h00 || got_q[n0+1] !== 8'hFF) begin
                bad++;
                $display("FAIL b2b_data got=%h,%h want=00,ff", got_q[n0], got_q[n0+1]);
            end
        end
    endtask

    task automatic test_glitch;
        int n0, e0;
        n0 = got_q.size();
        e0 = err_cnt;
        uart_rx = 1'b0;
        repeat (100) @(negedge sys_clk);
        uart_rx = 1'b1;
        idle_bits(2);
        total++;
        if (last_blen < 200 || last_blen > 230 || rx_busy !== 1'b0) begin
            bad++;
            $display("FAIL glitch_busy got=len%0d/now%b want=200..230/0", last_blen, rx_busy);
        end
        total++;
        if (got_q.size() !== n0 || err_cnt !== e0 || rx_overrun !== 1'b0) begin
            bad++;
            $display("FAIL glitch_flags got=valid%0d/err%0d/ovr%b want=0/0/0",
                     got_q.size() - n0, err_cnt - e0, rx_overrun);
        end
    endtask

    task automatic test_frame_err;
        int n0, e0;
        n0 = got_q.size();
        e0 = err_cnt;
        send_frame(8'h3C, 1'b0);
        idle_bits(1);
        total++;
        if (err_cnt !== e0 + 1 || last_elen !== 1) begin
            bad++;
            $display("FAIL ferr_pulse got=cnt%0d/len%0d want=1/1", err_cnt - e0, last_elen);
        end
        total++;
        if (got_q.size() !== n0 || rx_valid !== 1'b0) begin
            bad++;
            $display("FAIL ferr_novalid got=%0d want=0", got_q.size() - n0);
        end
    endtask

    task automatic test_overrun;
        rx_ack = 1'b0;
        send_frame(8'h11, 1'b1);
        idle_bits(1);
        send_frame(8'h22, 1'b1);
        idle_bits(1);
        total++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11 || rx_overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_hold got=v%b/d%h/o%b want=1/11/1", rx_valid, rx_data, rx_overrun);
        end
        rx_ack = 1'b1;
        @(negedge sys_clk);
        rx_ack = 1'b0;
        total++;
        if (rx_valid !== 1'b0 || rx_overrun !== 1'b0) begin
            bad++;
            $display("FAIL ovr_ack_clear got=v%b/o%b want=0/0", rx_valid, rx_overrun);
        end
        repeat (3) @(negedge sys_clk);
        rx_ack = 1'b1;
    endtask

    task automatic test_reset_mid_frame;
        int n0, e0;
        logic [7:0] b;
        b = 8'h5A;
        rx_ack = 1'b1;
        uart_rx = 1'b0;
        repeat (BIT) @(negedge sys_clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge sys_clk);
        end
        sys_rst_n = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge sys_clk);
        total++;
        if ({rx_valid, rx_busy, rx_frame_err, rx_overrun} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_mid_outputs got=%b want=0000",
                     {rx_valid, rx_busy, rx_frame_err, rx_overrun});
        end
        sys_rst_n = 1'b1;
        idle_bits(2);
        n0 = got_q.size();
        e0 = err_cnt;
        send_frame(8'hC3, 1'b1);
        idle_bits(1);
        total++;
        if (got_q.size() !== n0 + 1 || err_cnt !== e0) begin
            bad++;
            $display("FAIL rst_mid_count got=valid%0d/err%0d want=1/0", got_q.size() - n0, err_cnt - e0);
        end else begin
            total++;
            if (got_q[n0] !== 8'hC3) begin
                bad++;
                $display("FAIL rst_mid_data got=%h want=c3", got_q[n0]);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int n0, gap;
        n0 = got_q.size();
        rx_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 2);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            idle_bits(gap);
        end
        idle_bits(1);
        total++;
        if (got_q.size() !== n0 + exp_q.size()) begin
            bad++;
            $display("FAIL rand_count got=%0d want=%0d", got_q.size() - n0, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                total++;
                if (got_q[n0+k] !== exp_q[k]) begin
                    bad++;
                    $display("FAIL rand_data[%0d] got=%h want=%h", k, got_q[n0+k], exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        @(negedge sys_clk);
        test_reset;
        test_single_a5;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_overrun;
        test_reset_mid_frame;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
